alu_issue_wb: RTL and testbench
===============================

Name: alu_issue_wb

Overview:
- Sequential issue/writeback stage wrapped around the combinational ALU.
- Accepts one 16-bit instruction per handshake and reads operands from an internal 16x16 register file.
- Drives registered ALU inputs (op, a, b, carry-in), then captures the ALU result and flags into the register file and the processor status register (PSR).
- Sits between instruction fetch (upstream) and the ALU (combinational, instantiated beside it at top level).

Parameters:
- DATA_W, 16, datapath and register width.
- NREG, 16, number of general registers; address width is log2(NREG) = 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- inst_valid  in  1  fetch presents an instruction.
- inst  in  16  instruction: [15:12] opcode, [11:8] Rdest, [7:4] opext or imm hi, [3:0] Rsrc or imm lo.
- inst_ready  out  1  stage can accept; transfer when inst_valid && inst_ready.
- alu_op  out  8  ALU op code.
- alu_a  out  16  Rdest value.
- alu_b  out  16  Rsrc value or extended immediate.
- alu_c  out  1  carry-in, equal to PSR.C.
- alu_y  in  16  ALU result.
- alu_C, alu_L, alu_F, alu_Z, alu_N  in  1 each  ALU flags.
- psr  out  5  {C,L,F,Z,N}.
- wb_valid  out  1  one-cycle pulse when a register is written.
- wb_addr  out  4  register written.
- wb_data  out  16  value written.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- dbg_raddr  in  4  debug read address.
- dbg_rdata  out  16  debug read data, combinational from the register file.

Behaviour:
- Reset (async, active-high): all registers, psr, alu_* outputs, wb_* outputs and illegal clear to 0; FSM goes to IDLE; inst_ready=1 after reset deasserts.
- FSM states:
  - IDLE: inst_ready=1. On handshake, latch the instruction, decode, read operands, register alu_op/a/b/c, go to EXEC.
  - EXEC: inst_ready=0. ALU output settles this cycle; go to WB.
  - WB: inst_ready=0. On the clock edge, capture alu_y and flags; go to IDLE.
  - Latency: handshake at edge T, alu_* valid after T+1, result written at edge T+2, next accept at T+3. Throughput is 1 instruction per 3 cycles.
- Op formation:
  - inst[15:12] in {0000, 1000}: alu_op = {inst[15:12], inst[7:4]} and alu_b = R[inst[3:0]].
  - Exception inside 1000: LSHI (opext 0000) and RSHI (0001) use alu_b = zero-extended inst[3:0].
  - All other opcodes: alu_op = inst[15:8].
- Immediate extension:
  - ADDI, ADDCI, SUBI, CMPI (opcodes 0101, 0111, 1001, 1011): sign-extend inst[7:0].
  - ADDUI, ADDCUI, CMPUI (0110, 1010, 1110): zero-extend inst[7:0].
- Writeback:
  - Rdest = inst[11:8] is written with alu_y, except compares: CMP (0000/1011), CMPI (1011), CMPUI (1110).
  - Compares write only the PSR.
  - wb_valid pulses during WB for writing ops.
- PSR: updated during WB with {alu_C, alu_L, alu_F, alu_Z, alu_N} for every executed non-NOP instruction.
- NOP/WAIT (inst == 16'h0000):
  - Passes through IDLE, EXEC and WB.
  - No register write, no PSR change, alu_op = 0.
- Illegal (opcode-0000 opext outside {1,2,3,4,5,6,7,9,B,F}, opcode-1000 opext outside {0,1,4,5,C,D}, opcodes 0001-0100, 1100, 1101, 1111):
  - Treated as NOP.
  - illegal pulses one cycle in EXEC.
- Rdest == Rsrc: operands read from pre-write values; no hazard, since there is one instruction in flight.
- Reset asserted mid-operation: in-flight instruction discarded; register file and PSR cleared.
- inst_valid asserted while inst_ready=0: instruction is held by fetch, not dropped.

Optional Feature:
- Macro: ALU_ISSUE_R0_ZERO_EN.
- Defined:
  - R0 reads as 0 on all operand and debug paths.
  - Writes to R0 are suppressed; wb_valid still pulses with wb_addr=0.
  - PSR still updates.
- Undefined: R0 is an ordinary register.

Decomposition:
- Shared package alu_pkg holds:
  - opcode/opext localparams matching the ALU encoding;
  - PSR bit indices C=4, L=3, F=2, Z=1, N=0;
  - FSM state encoding IDLE/EXEC/WB.
- One natural sub-module: alu_regfile (NREG x DATA_W, two async read ports plus debug port, one sync write port, async reset clear).

Test Plan:
- Reset, then ADDI R1,#-1 (16'h51FF) -> alu_b=16'hFFFF at T+1; wb_valid with wb_addr=1, wb_data=16'hFFFF at T+2; psr.N=0, Z=0.
- R1=16'h7FFF, R2=1, ADD R1,R2 (16'h0152) -> wb_data=16'h8000; psr.F=1, C=0.
- R3=5, CMPI R3,#5 (16'hB305) -> no wb_valid, R3 unchanged; psr.Z=1, N=0.
- LSHI R4,#3 with R4=1 (16'h8403) -> alu_op=8'h80, alu_b=3, wb_data=16'h0008.
- inst=16'h1234 -> illegal pulse; no writeback; psr unchanged; inst_ready=1 three cycles after the handshake.
- Assert reset during EXEC of ADDI R5,#7 -> R5 reads 0 via dbg port; psr=0; FSM in IDLE with inst_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue/writeback stage: opcodes, opcode extensions,
// PSR bit positions, FSM states and the instruction decoder.
package alu_pkg;

    localparam logic [3:0] OPC_REG    = 4'h0;
    localparam logic [3:0] OPC_ADDI   = 4'h5;
    localparam logic [3:0] OPC_ADDUI  = 4'h6;
    localparam logic [3:0] OPC_ADDCI  = 4'h7;
    localparam logic [3:0] OPC_SHIFT  = 4'h8;
    localparam logic [3:0] OPC_SUBI   = 4'h9;
    localparam logic [3:0] OPC_ADDCUI = 4'hA;
    localparam logic [3:0] OPC_CMPI   = 4'hB;
    localparam logic [3:0] OPC_CMPUI  = 4'hE;

    localparam logic [3:0] EXT_LSHI   = 4'h0;
    localparam logic [3:0] EXT_RSHI   = 4'h1;
    localparam logic [3:0] EXT_CMP    = 4'hB;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BSRC_REG   = 2'd0,
        BSRC_SHAMT = 2'd1,
        BSRC_SEXT  = 2'd2,
        BSRC_ZEXT  = 2'd3
    } bsrc_t;

    typedef struct packed {
        logic       nop;
        logic       illegal;
        logic       wr;
        bsrc_t      bsrc;
        logic [7:0] op;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] inst);
        dec_t       d;
        logic [3:0] opc;
        logic [3:0] ext;
        opc       = inst[15:12];
        ext       = inst[7:4];
        d.nop     = 1'b0;
        d.illegal = 1'b0;
        d.wr      = 1'b1;
        d.bsrc    = BSRC_REG;
        d.op      = inst[15:8];
        case (opc)
            OPC_REG: begin
                d.op      = {opc, ext};
                d.illegal = !(ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hF});
                d.wr      = (ext != EXT_CMP);
            end
            OPC_SHIFT: begin
                d.op      = {opc, ext};
                d.illegal = !(ext inside {4'h0, 4'h1, 4'h4, 4'h5, 4'hC, 4'hD});
                if (ext == EXT_LSHI || ext == EXT_RSHI) d.bsrc = BSRC_SHAMT;
            end
            OPC_ADDI, OPC_ADDCI, OPC_SUBI: d.bsrc = BSRC_SEXT;
            OPC_CMPI: begin
                d.bsrc = BSRC_SEXT;
                d.wr   = 1'b0;
            end
            OPC_ADDUI, OPC_ADDCUI: d.bsrc = BSRC_ZEXT;
            OPC_CMPUI: begin
                d.bsrc = BSRC_ZEXT;
                d.wr   = 1'b0;
            end
            default: d.illegal = 1'b1;
        endcase
        // The all-zero word is the architectural NOP/WAIT, not an illegal opcode-0 form.
        if (inst == 16'h0000) d.illegal = 1'b0;
        d.nop = (inst == 16'h0000) || d.illegal;
        if (d.nop) begin
            d.wr = 1'b0;
            d.op = 8'h00;
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// General register file: two async operand read ports, an async debug port, one sync write.
// With ALU_ISSUE_R0_ZERO_EN defined, R0 reads as zero and ignores writes.
module alu_regfile #(
    parameter int  DATA_W = 16,
    parameter int  NREG   = 16,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    input  logic [AW-1:0]     dbg_raddr,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NREG];
    logic              we_eff;

`ifdef ALU_ISSUE_R0_ZERO_EN
    assign we_eff    = we && (waddr != '0);
    assign rdata_a   = (raddr_a   == '0) ? '0 : regs[raddr_a];
    assign rdata_b   = (raddr_b   == '0) ? '0 : regs[raddr_b];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
`else
    assign we_eff    = we;
    assign rdata_a   = regs[raddr_a];
    assign rdata_b   = regs[raddr_b];
    assign dbg_rdata = regs[dbg_raddr];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we_eff) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around an external combinational ALU: IDLE -> EXEC -> WB, one
// instruction in flight. Optional macro ALU_ISSUE_R0_ZERO_EN hardwires R0 to zero.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  NREG   = 16,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [15:0]       inst,
    output logic              inst_ready,
    output logic [7:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_c,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_C,
    input  logic              alu_L,
    input  logic              alu_F,
    input  logic              alu_Z,
    input  logic              alu_N,
    output logic [4:0]        psr,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    input  logic [AW-1:0]     dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output state_t            dbg_state
);

    // Handshake: an instruction transfers on a rising clk edge where inst_valid && inst_ready;
    // fetch must hold inst stable while inst_valid is high and inst_ready is low.
    state_t            state, state_nxt;
    dec_t              dec;
    logic              handshake;
    logic [DATA_W-1:0] rdata_a, rdata_b, b_sel;
    logic              pend_wr, pend_upd;
    logic [AW-1:0]     pend_addr;

    assign dec       = decode(inst);
    assign handshake = inst_valid && inst_ready;
    assign dbg_state = state;

    alu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk       (clk),
        .reset     (reset),
        .raddr_a   (inst[11:8]),
        .raddr_b   (inst[3:0]),
        .dbg_raddr (dbg_raddr),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .dbg_rdata (dbg_rdata),
        .we        (state == ST_WB && wb_valid),
        .waddr     (wb_addr),
        .wdata     (wb_data)
    );

    always_comb begin
        b_sel = rdata_b;
        case (dec.bsrc)
            BSRC_SHAMT: b_sel = {{(DATA_W-4){1'b0}}, inst[3:0]};
            BSRC_SEXT:  b_sel = {{(DATA_W-8){inst[7]}}, inst[7:0]};
            BSRC_ZEXT:  b_sel = {{(DATA_W-8){1'b0}}, inst[7:0]};
            default:    b_sel = rdata_b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (handshake) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_ready = (state == ST_IDLE);
    end

    // The ALU inputs stay put from issue until the next issue, so alu_y captured at the
    // end of EXEC and the flags captured at the end of WB describe the same operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c     <= 1'b0;
            illegal   <= 1'b0;
            pend_wr   <= 1'b0;
            pend_upd  <= 1'b0;
            pend_addr <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            psr       <= '0;
        end else begin
            illegal  <= 1'b0;
            wb_valid <= 1'b0;
            if (handshake) begin
                alu_op    <= dec.op;
                alu_a     <= rdata_a;
                alu_b     <= b_sel;
                alu_c     <= psr[PSR_C];
                illegal   <= dec.illegal;
                pend_wr   <= dec.wr;
                pend_upd  <= !dec.nop;
                pend_addr <= inst[11:8];
            end
            if (state == ST_EXEC) begin
                wb_valid <= pend_wr;
                wb_addr  <= pend_addr;
                wb_data  <= alu_y;
            end
            if (state == ST_WB && pend_upd) begin
                psr <= {alu_C, alu_L, alu_F, alu_Z, alu_N};
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural ALU beside the DUT, scoreboard queue filled at issue,
// monitor checking EXEC/WB/retire cycles, directed cases then randomized instructions.
module tb_alu_issue_wb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;
    logic [7:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_c, alu_C, alu_L, alu_F, alu_Z, alu_N;
    logic [4:0]  psr;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        illegal;
    logic [3:0]  dbg_raddr;
    logic [15:0] dbg_rdata;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    alu_issue_wb dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_y(alu_y),
        .alu_C(alu_C), .alu_L(alu_L), .alu_F(alu_F), .alu_Z(alu_Z), .alu_N(alu_N),
        .psr(psr), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ALU environment: returns {C,L,F,Z,N,y}
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic c);
        logic [16:0] s;
        logic [15:0] y;
        logic [4:0]  f;
        logic [3:0]  k;
        f = 5'd0;
        y = 16'd0;
        s = 17'd0;
        k = (op[7:4] == 4'h0) ? op[3:0] : op[7:4];
        if (op[7:4] == 4'h8) begin
            case (op[3:0])
                4'h0, 4'h4, 4'hC: y = a << b[3:0];
                4'h1, 4'h5:       y = a >> b[3:0];
                default:          y = 16'($signed(a) >>> b[3:0]);
            endcase
        end else begin
            case (k)
                4'h1: y = a & b;
                4'h2: y = a | b;
                4'h3: y = a ^ b;
                4'h4: y = b;
                4'h5, 4'h6, 4'h7, 4'hA: begin
                    s = {1'b0, a} + {1'b0, b} + {16'd0, (k == 4'h7 || k == 4'hA) ? c : 1'b0};
                    y = s[15:0];
                    f[4] = s[16];
                    f[2] = (a[15] == b[15]) && (y[15] != a[15]);
                end
                4'h9: begin
                    s = {1'b0, a} - {1'b0, b};
                    y = s[15:0];
                    f[4] = s[16];
                    f[2] = (a[15] != b[15]) && (y[15] != a[15]);
                end
                4'hB, 4'hE: begin
                    f[1] = (a == b);
                    f[3] = (b > a);
                    f[0] = ($signed(b) > $signed(a));
                end
                4'hF: y = 16'(a * b);
                default: y = 16'd0;
            endcase
        end
        return {f, y};
    endfunction

    logic [20:0] alu_res;
    always_comb alu_res = alu_fn(alu_op, alu_a, alu_b, alu_c);
    assign alu_y = alu_res[15:0];
    assign {alu_C, alu_L, alu_F, alu_Z, alu_N} = alu_res[20:16];

    // Reference model
    typedef struct packed {
        logic        ill;
        logic        ex;
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [4:0]  psr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_reg [16];
    logic [4:0]  m_psr;
    logic [15:0] lg_opc  = 16'h4FE1;
    logic [15:0] lg_ext0 = 16'b1000_1010_1111_1110;
    logic [15:0] lg_ext8 = 16'h3033;
    logic [15:0] sx_opc  = 16'h0AA0;

    function automatic logic [15:0] m_rd(input logic [3:0] r);
`ifdef ALU_ISSUE_R0_ZERO_EN
        if (r == 4'd0) return 16'd0;
`endif
        return m_reg[r];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 16; r++) m_reg[r] = 16'd0;
        m_psr = 5'd0;
    endtask

    task automatic model_issue(input logic [15:0] i);
        exp_t        e;
        logic [3:0]  opc, ext;
        logic        nop, cmp;
        logic [20:0] r;
        opc  = i[15:12];
        ext  = i[7:4];
        nop  = (i == 16'h0000);
        e.ill = !nop && (!lg_opc[opc] || (opc == 4'h0 && !lg_ext0[ext]) ||
                         (opc == 4'h8 && !lg_ext8[ext]));
        e.ex = !nop && !e.ill;
        e.a  = m_rd(i[11:8]);
        e.c  = m_psr[4];
        if (opc == 4'h0 || opc == 4'h8) begin
            e.op = {opc, ext};
            e.b  = (opc == 4'h8 && ext <= 4'h1) ? {12'd0, i[3:0]} : m_rd(i[3:0]);
        end else begin
            e.op = i[15:8];
            e.b  = sx_opc[opc] ? {{8{i[7]}}, i[7:0]} : {8'd0, i[7:0]};
        end
        if (!e.ex) e.op = 8'h00;
        cmp    = (opc == 4'h0 && ext == 4'hB) || opc == 4'hB || opc == 4'hE;
        r      = alu_fn(e.op, e.a, e.b, e.c);
        e.wr   = e.ex && !cmp;
        e.addr = i[11:8];
        e.data = r[15:0];
        if (e.ex) m_psr = r[20:16];
        e.psr  = m_psr;
        if (e.wr) begin
`ifdef ALU_ISSUE_R0_ZERO_EN
            if (e.addr != 4'd0) m_reg[e.addr] = e.data;
`else
            m_reg[e.addr] = e.data;
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: EXEC cycle detected by inst_ready falling, then WB, then the retire cycle.
    int   phase = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (reset) begin
            phase = 0;
        end else begin
            case (phase)
                0: begin
                    if (!inst_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_exec", 32'(exp_q.size()), 32'd1);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("exec_illegal", 32'(illegal), 32'(cur.ill));
                            chk("exec_alu_op", 32'(alu_op), 32'(cur.op));
                            if (cur.ex) begin
                                chk("exec_alu_a", 32'(alu_a), 32'(cur.a));
                                chk("exec_alu_b", 32'(alu_b), 32'(cur.b));
                                chk("exec_alu_c", 32'(alu_c), 32'(cur.c));
                            end
                        end
                        phase = 1;
                    end else begin
                        chk("idle_quiet", 32'({wb_valid, illegal}), 32'd0);
                    end
                end
                1: begin
                    chk("wb_valid", 32'(wb_valid), 32'(cur.wr));
                    chk("wb_not_ready", 32'(inst_ready), 32'd0);
                    if (cur.wr) begin
                        chk("wb_addr", 32'(wb_addr), 32'(cur.addr));
                        chk("wb_data", 32'(wb_data), 32'(cur.data));
                    end
                    phase = 2;
                end
                default: begin
                    chk("retire_psr", 32'(psr), 32'(cur.psr));
                    chk("retire_ready", 32'(inst_ready), 32'd1);
                    phase = 0;
                end
            endcase
        end
    end

    // Drivers: all called at 1ns after a rising edge.
    task automatic issue(input logic [15:0] i);
        int n;
        n = 0;
        inst_valid = 1'b1;
        inst = i;
        while (!inst_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!inst_ready) begin
            chk("issue_timeout", 32'(inst_ready), 32'd1);
            inst_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_issue(i);
            #1;
            inst_valid = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_dbg(input logic [3:0] r, output logic [15:0] v);
        dbg_raddr = r;
        #1;
        v = dbg_rdata;
    endtask

    logic [15:0] v;
    logic [3:0]  opcs [9] = '{4'h0, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE};

    initial begin
        reset = 1'b1;
        inst_valid = 1'b0;
        inst = 16'h0000;
        dbg_raddr = 4'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(inst_ready), 32'd1);
        chk("rst_psr", 32'(psr), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu", 32'({alu_op, alu_c}), 32'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
        rd_dbg(4'd7, v);
        chk("rst_r7", 32'(v), 32'd0);
        @(posedge clk);
        #1;

        issue(16'h51FF);
        chk("addi_alu_b", 32'(alu_b), 32'h0000FFFF);
        drain();
        rd_dbg(4'd1, v);
        chk("addi_r1", 32'(v), 32'h0000FFFF);
        chk("addi_psr_nz", 32'({psr[PSR_N], psr[PSR_Z]}), 32'd0);

        issue(16'h810F);
        issue(16'h51FF);
        issue(16'h6201);
        issue(16'h0152);
        drain();
        rd_dbg(4'd1, v);
        chk("add_r1", 32'(v), 32'h00008000);
        chk("add_psr_fc", 32'({psr[PSR_F], psr[PSR_C]}), 32'b10);

        issue(16'h6305);
        issue(16'hB305);
        drain();
        rd_dbg(4'd3, v);
        chk("cmpi_r3", 32'(v), 32'd5);
        chk("cmpi_psr_zn", 32'({psr[PSR_Z], psr[PSR_N]}), 32'b10);

        issue(16'h6401);
        issue(16'h8403);
        chk("lshi_alu_op", 32'(alu_op), 32'h80);
        chk("lshi_alu_b", 32'(alu_b), 32'd3);
        drain();
        rd_dbg(4'd4, v);
        chk("lshi_r4", 32'(v), 32'd8);

        issue(16'hB305);
        issue(16'h1234);
        chk("illegal_pulse", 32'(illegal), 32'd1);
        drain();
        chk("illegal_psr", 32'(psr), 32'b00010);
        rd_dbg(4'd2, v);
        chk("illegal_r2", 32'(v), 32'd1);

        issue(16'h5503);
        drain();
        issue(16'h5507);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_clear();
        #1;
        rd_dbg(4'd5, v);
        chk("midrst_r5", 32'(v), 32'd0);
        chk("midrst_psr", 32'(psr), 32'd0);
        chk("midrst_ready", 32'(inst_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_ready", 32'(inst_ready), 32'd1);

        for (int n = 0; n < 200; n++) begin
            int r;
            logic [15:0] i;
            r = $urandom_range(0, 9);
            if (r < 7)       i = {opcs[$urandom_range(0, 8)], 12'($urandom)};
            else if (r == 9) i = 16'h0000;
            else             i = 16'($urandom);
            issue(i);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        for (int r = 0; r < 16; r++) begin
            rd_dbg(4'(r), v);
            chk("final_reg", 32'(v), 32'(m_rd(4'(r))));
        end
        chk("final_psr", 32'(psr), 32'(m_psr));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
